dreg_arb: RTL and testbench
===========================

# dreg_arb

Round-robin arbiter and write sequencer that shares one gate-level W-bit D register, built from NAND-latch `ff` cells, among four requesters. It drives the register's data and clock inputs, waits a programmable settling time for the gate-delay chain, checks the readback against what was written, and reports completion and errors. It sits between the requester logic and the shared storage-cell bank.

## Interface
Parameters:
- `W`, 8: register width in bits.
- `SETTLE`, 2: number of wait cycles after the strobe before checking; legal range 1–15.

Ports:
- `c`, in, 1: clock, rising-edge.
- `r`, in, 1: reset, synchronous and active-high.
- `req`, in, 4: per-requester write request; bit i belongs to requester i.
- `wd`, in, 4*W: write data; slice `[i*W +: W]` belongs to requester i.
- `gnt`, out, 4: one-hot grant, held for the whole transaction.
- `done`, out, 1: one-cycle pulse at transaction end.
- `err`, out, 1: readback mismatch, valid only while `done` is 1.
- `err_cnt`, out, 8: saturating count of transactions that ended with `err`.
- `reg_d`, out, W: data driven to the shared register `d` inputs.
- `reg_c`, out, 1: clock strobe driven to the shared register `c` inputs.
- `reg_q`, in, W: register `q` readback.
- `reg_qn`, in, W: register `qn` readback.

## Operation
- All outputs are registered.
- Reset values: `gnt`=0, `done`=0, `err`=0, `err_cnt`=0, `reg_d`=0, `reg_c`=0. State resets to IDLE and the priority pointer `ptr` resets to 3, so requester 0 has highest priority first.
- Arbitration: the winner is the first set `req` bit searching from `ptr+1` upward, mod 4. In CHECK, `ptr` is set to the winner.
- FSM states and transitions:
  - IDLE: if any `req` bit is set, go to LOAD. On that edge, `gnt` is set to the winner's one-hot value and `reg_d` to the winner's `wd` slice.
  - LOAD: 1 cycle. `reg_c`=0, giving setup time on `reg_d`.
  - STROBE: 1 cycle. `reg_c`=1.
  - SETTLE: `reg_c`=0, lasting `SETTLE` cycles, counted by a 4-bit down-counter.
  - CHECK: 1 cycle. `done`=1 and `err`=(`reg_q`≠`reg_d`). If `err`=1 and `err_cnt`<255, `err_cnt` increments. Then go to IDLE; `gnt` clears on the exit edge.
- `wd` is sampled only on the IDLE→LOAD edge. Later changes to `wd` have no effect on the current transaction.
- Deasserting `req` during a transaction is ignored: the transaction completes and `done` still pulses.
- Requests arriving during a transaction wait for IDLE. No request is lost while `req` stays high.
- Reset asserted mid-transaction: all outputs and state take their reset values on the next edge, with no `done` pulse. `reg_d` may change while `reg_c`=0.

## Timing
- Let E0 be the IDLE edge that samples a request. Then:
  - `gnt` is high in cycles 1 … 3+`SETTLE`.
  - `reg_c` is high in cycle 2 only.
  - `done` is high in cycle 3+`SETTLE`.
  - The earliest next `gnt` is in cycle 5+`SETTLE`; IDLE always lasts at least 1 cycle.
- Throughput: one transaction every 4+`SETTLE` cycles under continuous requests.
- `reg_d` is stable from 1 cycle before the `reg_c` rising edge until CHECK ends.

## Configuration
- `DREG_ARB_QN_CHECK_EN` defined:
  - CHECK also flags `err` when `reg_qn`≠~`reg_q`. This detects a latch stuck in the metastable or both-high state.
  - `err_cnt` counts such transactions the same way.
- Not defined:
  - `reg_qn` is ignored and left unconnected internally.
  - `err` reflects only `reg_q`≠`reg_d`.

## Test plan
- Reset, then `req`=4'b0001, `wd[7:0]`=8'hA5, with an ideal register model (`q`=`d` two cycles after the `reg_c` rise):
  - `gnt`=0001 in cycles 1–5.
  - `reg_c` high in cycle 2.
  - `done`=1 and `err`=0 in cycle 5; `err_cnt`=0.
- `req`=4'b1111 held continuously:
  - Grants come in the order 0001, 0010, 0100, 1000, 0001.
  - Each grant starts 6 cycles after the previous one.
- Register model forces `q`=8'h00 while `wd` slice=8'hFF:
  - `done`=1 with `err`=1.
  - `err_cnt` increments by 1 per transaction and holds at 255 after 300 such transactions.
- `req[2]` pulses high for a single cycle, and `wd` changes in cycle 2:
  - Transaction completes and `done` pulses in cycle 5.
  - `reg_d` holds the value sampled at E0.
- `r`=1 in cycle 3 of a transaction: next cycle `gnt`=0, `reg_c`=0, `reg_d`=0, with no `done` pulse; after reset, requester 0 wins when all requesters request.
- With `DREG_ARB_QN_CHECK_EN` defined and the model returning `qn`=`q`=8'h3C for `wd`=8'h3C: `err`=1. Without the macro, the same stimulus gives `err`=0.

Source files
------------

// File: rtl/dreg_arb.sv
// rtl/dreg_arb.sv - round-robin arbiter and write/readback sequencer for a shared NAND-latch D register
// Optional: define DREG_ARB_QN_CHECK_EN to also flag reg_qn != ~reg_q at readback.
module dreg_arb #(
    parameter int W      = 8,
    parameter int SETTLE = 2
) (
    input  logic           c,
    input  logic           r,
    input  logic [3:0]     req,
    input  logic [4*W-1:0] wd,
    output logic [3:0]     gnt,
    output logic           done,
    output logic           err,
    output logic [7:0]     err_cnt,
    output logic [W-1:0]   reg_d,
    output logic           reg_c,
    input  logic [W-1:0]   reg_q,
    input  logic [W-1:0]   reg_qn
);
    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STROBE,
        S_SETTLE,
        S_CHECK
    } state_t;

    state_t         state, state_nx;
    logic [3:0]     cnt, cnt_nx;
    logic [1:0]     ptr, ptr_nx;
    logic [1:0]     cur, cur_nx;
    logic [1:0]     win, idx;
    logic           any_req;
    logic           mismatch;
    logic [W-1:0]   wd_a [4];

    logic [3:0]     gnt_nx;
    logic           done_nx, err_nx, reg_c_nx;
    logic [7:0]     err_cnt_nx;
    logic [W-1:0]   reg_d_nx;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            wd_a[i] = wd[i*W +: W];
        end
    end

    // Scan downward so the candidate closest to ptr+1 overwrites the others.
    always_comb begin
        win     = ptr;
        idx     = ptr;
        any_req = |req;
        for (int k = 4; k >= 1; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                win = idx;
            end
        end
    end

`ifdef DREG_ARB_QN_CHECK_EN
    // A latch stuck metastable or with both outputs high breaks q/qn complementarity.
    assign mismatch = (reg_q != reg_d) || (reg_qn != ~reg_q);
`else
    logic unused_qn;
    assign unused_qn = ^reg_qn;
    assign mismatch  = (reg_q != reg_d);
`endif

    always_ff @(posedge c) begin
        if (r) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            ptr     <= 2'd3;
            cur     <= 2'd0;
            gnt     <= 4'd0;
            done    <= 1'b0;
            err     <= 1'b0;
            err_cnt <= 8'd0;
            reg_d   <= '0;
            reg_c   <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            ptr     <= ptr_nx;
            cur     <= cur_nx;
            gnt     <= gnt_nx;
            done    <= done_nx;
            err     <= err_nx;
            err_cnt <= err_cnt_nx;
            reg_d   <= reg_d_nx;
            reg_c   <= reg_c_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_IDLE:   if (any_req) state_nx = S_LOAD;
            S_LOAD:   state_nx = S_STROBE;
            S_STROBE: begin
                state_nx = S_SETTLE;
                cnt_nx   = SETTLE_CNT;
            end
            S_SETTLE: begin
                if (cnt <= 4'd1) begin
                    state_nx = S_CHECK;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            S_CHECK:  state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Outputs are registered, so each value is computed for the state being entered.
    always_comb begin
        gnt_nx     = gnt;
        reg_d_nx   = reg_d;
        cur_nx     = cur;
        ptr_nx     = ptr;
        reg_c_nx   = 1'b0;
        done_nx    = 1'b0;
        err_nx     = 1'b0;
        err_cnt_nx = err_cnt;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    gnt_nx   = 4'b0001 << win;
                    reg_d_nx = wd_a[win];
                    cur_nx   = win;
                end
            end
            S_LOAD: reg_c_nx = 1'b1;
            S_SETTLE: begin
                if (cnt <= 4'd1) begin
                    done_nx = 1'b1;
                    err_nx  = mismatch;
                    if (mismatch && (err_cnt != 8'hFF)) begin
                        err_cnt_nx = err_cnt + 8'd1;
                    end
                end
            end
            S_CHECK: begin
                gnt_nx = 4'd0;
                ptr_nx = cur;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_dreg_arb.sv
// tb/tb_dreg_arb.sv - scoreboard bench for dreg_arb with a behavioural shared-register model
`timescale 1ns/1ps
module tb_dreg_arb;
    localparam int W = 8;
`ifdef DREG_ARB_QN_CHECK_EN
    localparam logic QN_ERR = 1'b1;
`else
    localparam logic QN_ERR = 1'b0;
`endif

    logic           c = 1'b0;
    logic           r = 1'b1;
    logic [3:0]     req = 4'd0;
    logic [4*W-1:0] wd = '0;
    logic [3:0]     gnt;
    logic           done, err, reg_c;
    logic [7:0]     err_cnt;
    logic [W-1:0]   reg_d;
    logic [W-1:0]   reg_q = '0;
    logic [W-1:0]   reg_qn = '1;

    int n_chk  = 0;
    int n_fail = 0;
    int mode   = 0;

    typedef struct packed {
        logic [3:0]   g;
        logic [W-1:0] d;
        logic         e;
        logic [7:0]   n;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    logic [W-1:0] q_m = '0;
    logic [W-1:0] pend = '0;
    int           dly = 0;

    dreg_arb #(.W(W), .SETTLE(2)) dut (
        .c(c), .r(r), .req(req), .wd(wd), .gnt(gnt), .done(done), .err(err),
        .err_cnt(err_cnt), .reg_d(reg_d), .reg_c(reg_c), .reg_q(reg_q), .reg_qn(reg_qn)
    );

    always #5 c = ~c;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge c);
            #1;
        end
    endtask

    task automatic push(input logic [3:0] g, input logic [W-1:0] d, input logic e, input logic [7:0] n);
        exp_t x;
        x.g = g;
        x.d = d;
        x.e = e;
        x.n = n;
        sb.push_back(x);
    endtask

    task automatic do_reset();
        r   = 1'b1;
        req = 4'd0;
        tick(2);
        r = 1'b0;
    endtask

    // Shared register: q follows d about two cycles after the strobe; mode injects faults.
    initial forever begin
        @(negedge c);
        if (reg_c) begin
            pend = reg_d;
            dly  = 2;
        end else if (dly > 0) begin
            dly--;
            if (dly == 0) q_m = pend;
        end
        reg_q  = (mode == 1) ? '0 : q_m;
        reg_qn = (mode == 2) ? reg_q : ~reg_q;
    end

    initial forever begin
        @(negedge c);
        if (done === 1'b1) begin
            check("done_expected", 32'(sb.size() > 0), 32'(1));
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("sb_gnt", 32'(gnt), 32'(mon_e.g));
                check("sb_reg_d", 32'(reg_d), 32'(mon_e.d));
                check("sb_err", 32'(err), 32'(mon_e.e));
                check("sb_err_cnt", 32'(err_cnt), 32'(mon_e.n));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] gs [5];
        int         st [5];
        int         ng;
        logic [3:0] prev;

        do_reset();
        check("rst_gnt", 32'(gnt), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        check("rst_err_cnt", 32'(err_cnt), 32'(0));
        check("rst_reg_d", 32'(reg_d), 32'(0));
        check("rst_reg_c", 32'(reg_c), 32'(0));

        // Single write from requester 0 with an ideal register.
        mode     = 0;
        wd[7:0]  = 8'hA5;
        req      = 4'b0001;
        push(4'b0001, 8'hA5, 1'b0, 8'd0);
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            if (k == 1) req = 4'd0;
            check("t1_gnt", 32'(gnt), (k <= 5) ? 32'(1) : 32'(0));
            check("t1_reg_c", 32'(reg_c), 32'(k == 2));
            check("t1_done", 32'(done), 32'(k == 5));
        end
        check("t1_sb_empty", 32'(sb.size()), 32'(0));

        // Continuous requests from everyone rotate 0,1,2,3,0 every 6 cycles.
        do_reset();
        wd = {8'h44, 8'h33, 8'h22, 8'h11};
        push(4'b0001, 8'h11, 1'b0, 8'd0);
        push(4'b0010, 8'h22, 1'b0, 8'd0);
        push(4'b0100, 8'h33, 1'b0, 8'd0);
        push(4'b1000, 8'h44, 1'b0, 8'd0);
        push(4'b0001, 8'h11, 1'b0, 8'd0);
        req  = 4'b1111;
        ng   = 0;
        prev = 4'd0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            tick(1);
            if (gnt != 4'd0 && prev == 4'd0 && ng < 5) begin
                gs[ng] = gnt;
                st[ng] = cyc;
                ng++;
                if (ng == 5) req = 4'd0;
            end
            prev = gnt;
        end
        check("t2_grants", 32'(ng), 32'(5));
        for (int i = 0; i < 5; i++) begin
            if (i < ng) begin
                check("t2_order", 32'(gs[i]), 32'(4'b0001 << (i % 4)));
                check("t2_start", 32'(st[i]), 32'(1 + 6 * i));
            end
        end
        check("t2_sb_empty", 32'(sb.size()), 32'(0));

        // Stuck-zero register: every transaction errors, counter saturates.
        do_reset();
        mode    = 1;
        wd[7:0] = 8'hFF;
        for (int i = 1; i <= 300; i++) begin
            push(4'b0001, 8'hFF, 1'b1, (i > 255) ? 8'd255 : 8'(i));
        end
        req  = 4'b0001;
        ng   = 0;
        prev = 4'd0;
        for (int cyc = 0; cyc < 2000 && ng < 300; cyc++) begin
            tick(1);
            if (gnt != 4'd0 && prev == 4'd0) begin
                ng++;
                if (ng == 300) req = 4'd0;
            end
            prev = gnt;
        end
        tick(8);
        check("t3_txns", 32'(ng), 32'(300));
        check("t3_err_cnt_sat", 32'(err_cnt), 32'(255));
        check("t3_sb_empty", 32'(sb.size()), 32'(0));

        // One-cycle req pulse; wd changes mid-transaction.
        do_reset();
        mode = 0;
        wd   = {8'h00, 8'h5A, 8'h00, 8'h00};
        req  = 4'b0100;
        push(4'b0100, 8'h5A, 1'b0, 8'd0);
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            if (k == 1) req = 4'd0;
            if (k == 2) wd = {8'hC3, 8'hC3, 8'hC3, 8'hC3};
            check("t4_done", 32'(done), 32'(k == 5));
            if (k <= 5) check("t4_reg_d", 32'(reg_d), 32'(8'h5A));
        end
        check("t4_sb_empty", 32'(sb.size()), 32'(0));

        // Reset in cycle 3 aborts silently; afterwards requester 0 wins.
        do_reset();
        wd  = {8'h44, 8'h33, 8'h22, 8'h11};
        req = 4'b0010;
        for (int k = 1; k <= 3; k++) begin
            tick(1);
            if (k == 1) req = 4'd0;
        end
        r = 1'b1;
        tick(1);
        check("t5_gnt", 32'(gnt), 32'(0));
        check("t5_reg_c", 32'(reg_c), 32'(0));
        check("t5_reg_d", 32'(reg_d), 32'(0));
        check("t5_done", 32'(done), 32'(0));
        r   = 1'b0;
        req = 4'b1111;
        push(4'b0001, 8'h11, 1'b0, 8'd0);
        tick(1);
        check("t5_first_gnt", 32'(gnt), 32'(4'b0001));
        req = 4'd0;
        tick(6);
        check("t5_sb_empty", 32'(sb.size()), 32'(0));

        // qn equal to q: an error only when the complement check is built in.
        do_reset();
        mode    = 2;
        wd[7:0] = 8'h3C;
        req     = 4'b0001;
        push(4'b0001, 8'h3C, QN_ERR, QN_ERR ? 8'd1 : 8'd0);
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            if (k == 1) req = 4'd0;
            if (k == 5) check("t6_err", 32'(err), 32'(QN_ERR));
        end
        check("t6_sb_empty", 32'(sb.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
